mux4_1_rr_pkt: RTL
==================

Name: mux4_1_rr_pkt

Overview:
- 4-to-1 packet multiplexer that merges four valid/ready input lanes onto one output lane. It is the inverse of the team's 1:4 demux.
- Round-robin arbitration at packet granularity: once a lane is granted, it keeps the output until its last beat.
- The output carries a registered 2-bit lane code (S2,S1) so a downstream 1:4 demux can route the data back out.
- Sits between four producer lanes and a shared serial datapath.

Parameters:
- DW, 8, data width of every lane.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  4  per-lane valid; bit i belongs to lane i.
- in_last  in  4  per-lane end-of-packet flag, qualified by in_valid[i].
- in_data0, in_data1, in_data2, in_data3  in  DW each  lane payloads.
- in_ready  out  4  per-lane ready, combinational; at most one bit is high.
- out_valid  out  1  output beat valid (registered).
- out_data  out  DW  output payload (registered).
- out_last  out  1  output end-of-packet (registered).
- S2  out  1  lane-code MSB of the current output beat (registered).
- S1  out  1  lane-code LSB of the current output beat (registered).
- out_ready  in  1  downstream accept.

Behaviour:
- Transfer rule: a lane transfers on a cycle where in_valid[i]&in_ready[i]. The output transfers on a cycle where out_valid&out_ready.
- Reset, synchronous, takes priority over everything:
  - out_valid=0, out_data=0, out_last=0, S2=0, S1=0.
  - FSM goes to IDLE.
  - Round-robin pointer ptr=0.
  - Lock lane lk=0.
  - A reset mid-packet drops the packet; no partial beats are emitted afterward.
- Output register is one entry. It can load on a cycle when load_ok = !out_valid | out_ready, which gives full throughput of 1 beat/cycle.
- FSM IDLE:
  - When load_ok is set and any in_valid is high, grant the first valid lane searching ptr, ptr+1, … (mod 4).
  - in_ready[g]=1 for that lane only.
  - The beat is loaded: out_data=in_data_g, out_last=in_last[g], {S2,S1}=g, out_valid=1.
  - If in_last[g]=1 (single-beat packet): stay in IDLE, ptr<=g+1 mod 4.
  - Otherwise: go to LOCKED, lk<=g.
- FSM LOCKED:
  - in_ready[lk]=load_ok. Every other in_ready bit is 0, even when those lanes are valid.
  - Each transferred beat loads the output register as in IDLE.
  - When the transferred beat has in_last[lk]=1: go to IDLE, ptr<=lk+1 mod 4.
  - While in_valid[lk]=0: wait in LOCKED and issue no grants.
- Output hold: if out_valid=1 and out_ready=0, all output signals hold and all in_ready are 0.
- Drain: if out_ready=1 and no new beat is loaded, out_valid<=0 on the next edge. out_data, out_last and {S2,S1} keep their last values.
- Latency: an input beat appears on the output the cycle after its transfer. There is no combinational path from in_* to out_*.
- Pointer wrap: lane 3 grant gives ptr=0.
- No lane valid in IDLE: no grant, ptr unchanged.
- Lane-code encoding matches the demux: lane0={S2,S1}=00, lane1=01, lane2=10, lane3=11.

Test Plan:
- Reset with all lanes valid, and rst asserted mid-packet → next cycle out_valid=0, S2=S1=0, in_ready=0000, FSM IDLE, ptr=0.
- All four lanes valid, single-beat packets (in_last=1111), data 0xA0..0xA3, out_ready=1 → outputs A0,A1,A2,A3,A0… on consecutive cycles with {S2,S1}=00,01,10,11,00. A new beat arrives every cycle.
- Lane 1 sends a 3-beat packet (0x11,0x12,0x13 with last on beat 3) while lane 2 is valid → lane 2 sees in_ready=0 for 3 transfers. 0x11–0x13 appear with {S2,S1}=01, then lane 2 is granted.
- Backpressure: out_ready=0 for 4 cycles with a beat held (0x55, {S2,S1}=10) → outputs stable, in_ready=0000. With out_ready=1, 0x55 transfers and the next beat loads in the same cycle.
- Locked lane 3 drops in_valid for 2 cycles mid-packet while lane 0 is valid → no grant to lane 0. The packet resumes, then ptr wraps to 0 and lane 0 is served next.
- Only lane 2 valid with ptr=3 → grant lane 2. ptr becomes 3 afterward.

Source files
------------

// File: rtl/mux4_1_rr_pkt.sv
// Four-lane to one-lane packet mux with packet-granular round-robin arbitration.
// The output beat is registered together with a 2-bit lane code {S2,S1} for the downstream 1:4 demux.
module mux4_1_rr_pkt #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    in_valid,
    input  logic [3:0]    in_last,
    input  logic [DW-1:0] in_data0,
    input  logic [DW-1:0] in_data1,
    input  logic [DW-1:0] in_data2,
    input  logic [DW-1:0] in_data3,
    output logic [3:0]    in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          S2,
    output logic          S1,
    input  logic          out_ready
);

    localparam int unsigned NL = 4;
    localparam int unsigned LW = 2;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   ptr_q, ptr_d;
    logic [LW-1:0]   lk_q, lk_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [LW-1:0]   code_q, code_d;

    logic            load_ok;
    logic            grant_vld;
    logic [LW-1:0]   grant;
    logic [LW-1:0]   idx;
    logic [LW-1:0]   sel;
    logic            sel_last;
    logic [DW-1:0]   sel_data;
    logic            xfer;

    assign load_ok = !out_valid_q || out_ready;

    // Round-robin search: scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant     = ptr_q;
        idx       = ptr_q;
        for (int k = NL - 1; k >= 0; k--) begin
            idx = ptr_q + LW'(k);
            if (in_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    assign sel      = (state_q == LOCKED) ? lk_q : grant;
    assign sel_last = in_last[sel];

    always_comb begin
        sel_data = in_data0;
        case (sel)
            2'd0:    sel_data = in_data0;
            2'd1:    sel_data = in_data1;
            2'd2:    sel_data = in_data2;
            default: sel_data = in_data3;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lk_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lk_q    <= lk_d;
        end
    end

    // Next-state logic: a transferred last beat releases the lane and advances the pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lk_d    = lk_q;
        if (xfer) begin
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = sel + LW'(1);
            end else begin
                state_d = LOCKED;
                lk_d    = sel;
            end
        end
    end

    // Output logic: at most one ready bit, and none while held off or in reset.
    always_comb begin
        in_ready = '0;
        if (!rst) begin
            case (state_q)
                IDLE:    if (load_ok && grant_vld) in_ready[grant] = 1'b1;
                default: in_ready[lk_q] = load_ok;
            endcase
        end
    end

    assign xfer = |(in_valid & in_ready);

    // Single-entry output register; payload keeps its last value when draining.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        code_d      = code_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            code_d      = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            code_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            code_q      <= code_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign S2        = code_q[1];
    assign S1        = code_q[0];

endmodule
